// File: rtl/gpr_write_arbiter.sv
// Round-robin arbiter sharing the single GPR write port among num_req write-back requesters,
// with a one-cycle registered write and combinational read forwarding from that write.
`ifndef L2_REG_FILE_SIZE
`define L2_REG_FILE_SIZE 5
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module gpr_write_arbiter #(
  parameter int num_req     = 3,
  parameter int l2_num_regs = `L2_REG_FILE_SIZE,
  parameter int word_size   = `WORD_SIZE
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [num_req-1:0]             i_req_valid,
  input  logic [num_req*l2_num_regs-1:0] i_req_sel,
  input  logic [num_req*word_size-1:0]   i_req_data,
  output logic [num_req-1:0]             o_req_ready,
  input  logic                           i_hold,
  output logic                           o_load_gpr,
  output logic [l2_num_regs-1:0]         o_load_gpr_sel,
  output logic [word_size-1:0]           o_load_gpr_data,
  input  logic [l2_num_regs-1:0]         i_read_A_sel,
  input  logic [l2_num_regs-1:0]         i_read_B_sel,
  input  logic [word_size-1:0]           i_rf_A_data,
  input  logic [word_size-1:0]           i_rf_B_data,
  output logic [word_size-1:0]           o_read_A_data,
  output logic [word_size-1:0]           o_read_B_data
);

  localparam int PW = (num_req > 1) ? $clog2(num_req) : 1;

  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   load_q, load_d;
  logic [l2_num_regs-1:0] sel_q, sel_d;
  logic [word_size-1:0]   data_q, data_d;

  logic [num_req-1:0]     grant;
  logic                   found;
  logic [PW-1:0]          gidx;

  // Scan from ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    int idx;
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    if (!i_rst && !i_hold) begin
      for (int i = 0; i < num_req; i++) begin
        idx = (int'(ptr_q) + i) % num_req;
        if (!found && i_req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = idx[PW-1:0];
        end
      end
    end
  end

  assign o_req_ready = grant;

  always_comb begin
    ptr_d  = ptr_q;
    load_d = 1'b0;
    sel_d  = sel_q;
    data_d = data_q;
    if (found) begin
      ptr_d  = (int'(gidx) == num_req - 1) ? '0 : gidx + PW'(1);
      sel_d  = i_req_sel[gidx*l2_num_regs +: l2_num_regs];
      data_d = i_req_data[gidx*word_size +: word_size];
      // r0 is hard-wired: the write is consumed but never reaches the file.
      load_d = (sel_d != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q  <= '0;
      load_q <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      load_q <= load_d;
      sel_q  <= sel_d;
      data_q <= data_d;
    end
  end

  assign o_load_gpr      = load_q;
  assign o_load_gpr_sel  = sel_q;
  assign o_load_gpr_data = data_q;

  assign o_read_A_data = (load_q && (sel_q == i_read_A_sel)) ? data_q : i_rf_A_data;
  assign o_read_B_data = (load_q && (sel_q == i_read_B_sel)) ? data_q : i_rf_B_data;

endmodule

// File: doc/gpr_write_arbiter.md
GPR_WRITE_ARBITER -- requirements
Module: gpr_write_arbiter

Interface
REQ-001 Parameter num_req, default 3: number of write-back requesters sharing the single GPR write port.
REQ-002 Parameter l2_num_regs, default `L2_REG_FILE_SIZE: width of every register select.
REQ-003 Parameter word_size, default `WORD_SIZE: width of every data word.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 i_clk  in  1  clock; all state SHALL update on the posedge.
REQ-006 i_rst  in  1  synchronous reset, active-high.
REQ-007 i_req_valid  in  num_req  per-requester write request.
REQ-008 i_req_sel  in  num_req*l2_num_regs  per-requester destination register, packed; requester k occupies slice k.
REQ-009 i_req_data  in  num_req*word_size  per-requester write data, packed; requester k occupies slice k.
REQ-010 o_req_ready  out  num_req  one-hot-or-zero grant.
REQ-011 i_hold  in  1  pipeline hold; blocks all grants.
REQ-012 o_load_gpr  out  1  registered write enable to the register file.
REQ-013 o_load_gpr_sel  out  l2_num_regs  registered write select.
REQ-014 o_load_gpr_data  out  word_size  registered write data.
REQ-015 i_read_A_sel, i_read_B_sel  in  l2_num_regs  register file read selects (tapped).
REQ-016 i_rf_A_data, i_rf_B_data  in  word_size  raw register file read data.
REQ-017 o_read_A_data, o_read_B_data  out  word_size  forwarded read data.

Function
REQ-018 Transfer from requester k SHALL occur in a cycle where i_req_valid[k] and o_req_ready[k] are both 1.
REQ-019 Requesters SHALL hold valid, sel and data stable until transfer; valid SHALL NOT depend combinationally on ready.
REQ-020 o_req_ready SHALL be combinational from i_req_valid, the pointer, i_hold and i_rst.
REQ-021 o_req_ready SHALL be all-zero when i_hold=1, when i_rst=1, or when no valid is asserted.
REQ-022 Round-robin pointer ptr (0..num_req-1): the grant SHALL go to the first valid requester at index ptr, ptr+1, ... wrapping modulo num_req.
REQ-023 On a transfer from k, ptr SHALL become (k+1) mod num_req; with no transfer, ptr SHALL hold.
REQ-024 Latency SHALL be 1 cycle: the cycle after a transfer, o_load_gpr_sel and o_load_gpr_data SHALL equal the granted sel and data.
REQ-025 In that cycle, o_load_gpr SHALL be 1 iff the granted sel is non-zero.
REQ-026 A write to r0 SHALL be accepted (ready, ptr advances) but SHALL produce o_load_gpr=0.
REQ-027 With no transfer, o_load_gpr SHALL be 0 the next cycle, and o_load_gpr_sel and o_load_gpr_data SHALL hold their values.
REQ-028 Forwarding: if o_load_gpr=1 and o_load_gpr_sel == i_read_A_sel, o_read_A_data SHALL be o_load_gpr_data; otherwise it SHALL be i_rf_A_data. Port B SHALL be identical.
REQ-029 Forwarding SHALL be combinational, with zero latency.
REQ-030 Throughput SHALL be one transfer per cycle with back-to-back grants.
REQ-031 With all requesters continuously valid, each SHALL be granted once every num_req cycles.

Reset
REQ-032 While i_rst=1 at a posedge: ptr SHALL become 0, o_load_gpr 0, o_load_gpr_sel 0 and o_load_gpr_data 0.
REQ-033 o_req_ready SHALL be 0 throughout any reset cycle.
REQ-034 Reset asserted the cycle after a transfer SHALL drop o_load_gpr to 0 at that posedge; that pending write is lost.
REQ-035 The first grant after reset SHALL go to the lowest-index valid requester.

Verification
REQ-036 Reset, then valid=3'b111 held: grants SHALL be 0,1,2,0 on consecutive cycles; o_load_gpr=1 from the second cycle on.
REQ-037 ptr=1, valid=3'b101: requester 2 SHALL be granted, then ptr SHALL be 0 and requester 0 granted the next cycle.
REQ-038 Requester 0 valid, sel=0, data=0xDEADBEEF: ready SHALL be 1, o_load_gpr=0 next cycle, and ptr SHALL be 1.
REQ-039 Transfer sel=5, data=0x12345678; next cycle i_read_A_sel=5 with i_rf_A_data=0: o_read_A_data SHALL be 0x12345678. i_read_B_sel=6 SHALL pass i_rf_B_data through.
REQ-040 i_hold=1 for 3 cycles with valid=3'b010: ready SHALL be 0, o_load_gpr 0 and ptr unchanged; grant SHALL follow the cycle hold drops.
REQ-041 Transfer sel=7, then i_rst=1 the next cycle: o_load_gpr SHALL be 0 after that posedge, and ptr SHALL be 0.
